pwr_pat_seq: RTL and testbench

Consumer end of the button-driven pattern-select interface: takes the 8-bit pattern number produced by the front-panel switch logic, sequences the four panel supply rails up and down, and hands new pattern numbers to the timing generator only on frame boundaries. Pattern `PATMAX` is the power-off request. It sits between the switch/debounce block and the pattern/timing generator, and replaces the hard-wired rail enables.

---
 rtl/pwr_pat_seq_if.sv | 24 ++
 rtl/pwr_pat_seq.sv | 120 ++++++++++++
 tb/tb_pwr_pat_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pwr_pat_seq_if.sv
// Pattern-select / rail-control bundle between the switch block (master)
// and the pattern/power sequencer (slave).
interface pwr_pat_seq_if;
    logic [7:0] dis_sn;
    logic       frame_start;
    logic [7:0] pat_sn;
    logic       pat_upd;
    logic       en_p14v;
    logic       en_n14v;
    logic       en_gvddp;
    logic       en_gvddn;
    logic       pwr_ok;
    logic       busy;

    modport master (
        output dis_sn, frame_start,
        input  pat_sn, pat_upd, en_p14v, en_n14v, en_gvddp, en_gvddn, pwr_ok, busy
    );

    modport slave (
        input  dis_sn, frame_start,
        output pat_sn, pat_upd, en_p14v, en_n14v, en_gvddp, en_gvddn, pwr_ok, busy
    );
endinterface

// File: rtl/pwr_pat_seq.sv
// Panel rail sequencer and frame-synchronous pattern latch.
// Rails ramp up p14v->n14v->gvddp->gvddn and down in reverse, one rail per
// step period; PATMAX on dis_sn requests power-off.
module pwr_pat_seq #(
    parameter int         CNT1US  = 81,
    parameter int         STEP_US = 1000,
    parameter logic [7:0] PATMIN  = 8'd127,
    parameter logic [7:0] PATMAX  = 8'd255
) (
    input  logic          clk,
    input  logic          rst,
    pwr_pat_seq_if.slave  bus
);

    localparam int PW = (CNT1US  > 1) ? $clog2(CNT1US)  : 1;
    localparam int SW = (STEP_US > 1) ? $clog2(STEP_US) : 1;

    typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [3:0]  en, en_nxt;          // {gvddn, gvddp, n14v, p14v}
    logic [PW-1:0] pre;
    logic [SW-1:0] stp;
    logic        tick_1us, step_done;
    logic        want_on;
    logic        pwr_ok_r, busy_r;
    logic [7:0]  pat_sn_r, dis_clamp;
    logic        pat_upd_r, pat_go;

    assign want_on   = (bus.dis_sn != PATMAX);
    assign tick_1us  = (pre == PW'(CNT1US - 1));
    assign step_done = tick_1us && (stp == SW'(STEP_US - 1));

    // Timebase: runs only while ramping; any state change restarts it so the
    // first step lands exactly one period after entry.
    always_ff @(posedge clk) begin
        if (rst || (state_nxt != state) || !(state == S_UP || state == S_DOWN)) begin
            pre <= '0;
            stp <= '0;
        end else if (tick_1us) begin
            pre <= '0;
            stp <= step_done ? '0 : stp + SW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Next-state and next-enable decode; ramps are never aborted.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        en_nxt    = en;
        case (state)
            S_OFF: if (want_on) begin
                state_nxt = S_UP;
                idx_nxt   = 2'd0;
            end
            S_UP: if (step_done) begin
                en_nxt[idx] = 1'b1;
                idx_nxt     = idx + 2'd1;
                if (idx == 2'd3) state_nxt = S_ON;
            end
            S_ON: if (!want_on) begin
                state_nxt = S_DOWN;
                idx_nxt   = 2'd3;
            end
            S_DOWN: if (step_done) begin
                en_nxt[idx] = 1'b0;
                idx_nxt     = idx - 2'd1;
                if (idx == 2'd0) state_nxt = S_OFF;
            end
            default: state_nxt = S_OFF;
        endcase
    end

    // FSM state and registered rail/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_OFF;
            idx      <= 2'd0;
            en       <= 4'b0000;
            pwr_ok_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            en       <= en_nxt;
            pwr_ok_r <= (state_nxt == S_ON);
            busy_r   <= (state_nxt == S_UP) || (state_nxt == S_DOWN);
        end
    end

    // Compare the clamped value so a repeated sub-PATMIN request does not
    // pulse pat_upd without pat_sn actually changing.
    assign dis_clamp = (bus.dis_sn < PATMIN) ? PATMIN : bus.dis_sn;
    assign pat_go    = (state == S_ON) && bus.frame_start && want_on
                       && (dis_clamp != pat_sn_r);

    // Pattern latch: new pattern only on a frame boundary while powered.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_sn_r  <= PATMIN;
            pat_upd_r <= 1'b0;
        end else begin
            pat_upd_r <= pat_go;
            if (pat_go) pat_sn_r <= dis_clamp;
        end
    end

    assign bus.en_p14v  = en[0];
    assign bus.en_n14v  = en[1];
    assign bus.en_gvddp = en[2];
    assign bus.en_gvddn = en[3];
    assign bus.pwr_ok   = pwr_ok_r;
    assign bus.busy     = busy_r;
    assign bus.pat_sn   = pat_sn_r;
    assign bus.pat_upd  = pat_upd_r;

endmodule

// File: tb/tb_pwr_pat_seq.sv
// Directed bench for pwr_pat_seq with an 8-cycle rail step (CNT1US=4, STEP_US=2).
module tb_pwr_pat_seq;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pwr_pat_seq_if bif ();

    pwr_pat_seq #(
        .CNT1US  (4),
        .STEP_US (2),
        .PATMIN  (8'd127),
        .PATMAX  (8'd255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] dis;
        logic       fs;
        int         n;      // clock edges to advance before checking
        logic [3:0] en;     // {gvddn, gvddp, n14v, p14v}
        logic       pok;
        logic       busy;
        logic [7:0] pat;
        logic       upd;
    } vec_t;

    vec_t tbl [0:25];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] en, input logic pok,
                           input logic busy, input logic [7:0] pat, input logic upd);
        chk({nm, ".en"},   {bif.en_gvddn, bif.en_gvddp, bif.en_n14v, bif.en_p14v}, en);
        chk({nm, ".pok"},  bif.pwr_ok,  pok);
        chk({nm, ".busy"}, bif.busy,    busy);
        chk({nm, ".pat"},  bif.pat_sn,  pat);
        chk({nm, ".upd"},  bif.pat_upd, upd);
    endtask

    initial begin
        // reset, ramp up (edges counted from rst release)
        tbl[0]  = '{1'b1, 8'd127, 1'b0, 2, 4'b0000, 1'b0, 1'b0, 8'd127, 1'b0};
        tbl[1]  = '{1'b0, 8'd127, 1'b0, 1, 4'b0000, 1'b0, 1'b1, 8'd127, 1'b0}; // 1
        tbl[2]  = '{1'b0, 8'd127, 1'b0, 7, 4'b0000, 1'b0, 1'b1, 8'd127, 1'b0}; // 8
        tbl[3]  = '{1'b0, 8'd127, 1'b0, 1, 4'b0001, 1'b0, 1'b1, 8'd127, 1'b0}; // 9
        tbl[4]  = '{1'b0, 8'd127, 1'b0, 7, 4'b0001, 1'b0, 1'b1, 8'd127, 1'b0}; // 16
        tbl[5]  = '{1'b0, 8'd127, 1'b0, 1, 4'b0011, 1'b0, 1'b1, 8'd127, 1'b0}; // 17
        tbl[6]  = '{1'b0, 8'd127, 1'b0, 8, 4'b0111, 1'b0, 1'b1, 8'd127, 1'b0}; // 25
        tbl[7]  = '{1'b0, 8'd127, 1'b0, 7, 4'b0111, 1'b0, 1'b1, 8'd127, 1'b0}; // 32
        tbl[8]  = '{1'b0, 8'd127, 1'b0, 1, 4'b1111, 1'b1, 1'b0, 8'd127, 1'b0}; // 33
        // pattern updates in ON
        tbl[9]  = '{1'b0, 8'd130, 1'b0, 5, 4'b1111, 1'b1, 1'b0, 8'd127, 1'b0};
        tbl[10] = '{1'b0, 8'd130, 1'b1, 1, 4'b1111, 1'b1, 1'b0, 8'd130, 1'b1};
        tbl[11] = '{1'b0, 8'd130, 1'b0, 1, 4'b1111, 1'b1, 1'b0, 8'd130, 1'b0};
        tbl[12] = '{1'b0, 8'd130, 1'b1, 1, 4'b1111, 1'b1, 1'b0, 8'd130, 1'b0};
        tbl[13] = '{1'b0, 8'd131, 1'b0, 1, 4'b1111, 1'b1, 1'b0, 8'd130, 1'b0};
        tbl[14] = '{1'b0, 8'd130, 1'b0, 1, 4'b1111, 1'b1, 1'b0, 8'd130, 1'b0};
        tbl[15] = '{1'b0, 8'd130, 1'b1, 1, 4'b1111, 1'b1, 1'b0, 8'd130, 1'b0};
        tbl[16] = '{1'b0, 8'd100, 1'b1, 1, 4'b1111, 1'b1, 1'b0, 8'd127, 1'b1};
        tbl[17] = '{1'b0, 8'd100, 1'b0, 1, 4'b1111, 1'b1, 1'b0, 8'd127, 1'b0};
        // power-off request coincident with frame_start (edges from request)
        tbl[18] = '{1'b0, 8'd255, 1'b1, 1, 4'b1111, 1'b0, 1'b1, 8'd127, 1'b0}; // +1
        tbl[19] = '{1'b0, 8'd255, 1'b0, 7, 4'b1111, 1'b0, 1'b1, 8'd127, 1'b0}; // +8
        tbl[20] = '{1'b0, 8'd255, 1'b0, 1, 4'b0111, 1'b0, 1'b1, 8'd127, 1'b0}; // +9
        tbl[21] = '{1'b0, 8'd255, 1'b0, 8, 4'b0011, 1'b0, 1'b1, 8'd127, 1'b0}; // +17
        tbl[22] = '{1'b0, 8'd255, 1'b0, 8, 4'b0001, 1'b0, 1'b1, 8'd127, 1'b0}; // +25
        tbl[23] = '{1'b0, 8'd255, 1'b0, 7, 4'b0001, 1'b0, 1'b1, 8'd127, 1'b0}; // +32
        tbl[24] = '{1'b0, 8'd255, 1'b0, 1, 4'b0000, 1'b0, 1'b0, 8'd127, 1'b0}; // +33
        tbl[25] = '{1'b0, 8'd255, 1'b0, 3, 4'b0000, 1'b0, 1'b0, 8'd127, 1'b0}; // stays OFF

        clk             = 1'b0;
        rst             = 1'b1;
        bif.dis_sn      = 8'd127;
        bif.frame_start = 1'b0;

        for (int i = 0; i < 26; i++) begin
            rst             = tbl[i].rst;
            bif.dis_sn      = tbl[i].dis;
            bif.frame_start = tbl[i].fs;
            step(tbl[i].n);
            chk_out($sformatf("v%0d", i), tbl[i].en, tbl[i].pok, tbl[i].busy,
                    tbl[i].pat, tbl[i].upd);
        end
        bif.frame_start = 1'b0;

        // Request returns during DOWN: ramp completes, then UP restarts.
        bif.dis_sn = 8'd140;
        step(1);  chk_out("a_up1",  4'b0000, 1'b0, 1'b1, 8'd127, 1'b0);
        step(31); chk_out("a_up32", 4'b0111, 1'b0, 1'b1, 8'd127, 1'b0);
        step(1);  chk_out("a_on",   4'b1111, 1'b1, 1'b0, 8'd127, 1'b0);
        bif.dis_sn = 8'd255;
        step(1);  chk_out("a_dn1",  4'b1111, 1'b0, 1'b1, 8'd127, 1'b0);
        step(10); chk_out("a_dn11", 4'b0111, 1'b0, 1'b1, 8'd127, 1'b0);
        bif.dis_sn = 8'd140;
        step(21); chk_out("a_dn32", 4'b0001, 1'b0, 1'b1, 8'd127, 1'b0);
        step(1);  chk_out("a_off",  4'b0000, 1'b0, 1'b0, 8'd127, 1'b0);
        step(1);  chk_out("a_re1",  4'b0000, 1'b0, 1'b1, 8'd127, 1'b0);
        step(8);  chk_out("a_re9",  4'b0001, 1'b0, 1'b1, 8'd127, 1'b0);
        step(24); chk_out("a_reon", 4'b1111, 1'b1, 1'b0, 8'd127, 1'b0);
        bif.frame_start = 1'b1;
        step(1);  chk_out("a_pat",  4'b1111, 1'b1, 1'b0, 8'd140, 1'b1);
        bif.frame_start = 1'b0;
        step(1);  chk_out("a_pat2", 4'b1111, 1'b1, 1'b0, 8'd140, 1'b0);

        // Reset mid-ramp: everything back to reset values, ramp restarts.
        rst = 1'b1;
        step(1);  chk_out("b_rst0", 4'b0000, 1'b0, 1'b0, 8'd127, 1'b0);
        rst = 1'b0;
        step(1);  chk_out("b_up1",  4'b0000, 1'b0, 1'b1, 8'd127, 1'b0);
        step(19); chk_out("b_up20", 4'b0011, 1'b0, 1'b1, 8'd127, 1'b0);
        rst = 1'b1;
        step(1);  chk_out("b_rst",  4'b0000, 1'b0, 1'b0, 8'd127, 1'b0);
        rst = 1'b0;
        step(8);  chk_out("b_r8",   4'b0000, 1'b0, 1'b1, 8'd127, 1'b0);
        step(1);  chk_out("b_r9",   4'b0001, 1'b0, 1'b1, 8'd127, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
